c7bifu_iq: RTL and testbench
============================

# c7bifu_iq

Instruction queue between the fetch control/ICU return path and decode. It captures each valid instruction word returned by the ICU, together with its fetch PC, into a small FIFO. It presents the oldest entry to decode, which pops it under `stall` backpressure. It produces `iq_full` back to fetch control so that a fetch is never issued without guaranteed space for its return data, and it empties completely on `flush`.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `INSTR_W`, 32: instruction word width.
- `PC_W`, 32: PC width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch/except/ertn redirect from fetch control.
- `icu_data_vld`  in  1  ICU data valid, already masked for cancelled fetches.
- `icu_data`  in  INSTR_W  instruction word; qualified by `icu_data_vld`.
- `fetch_pc`  in  PC_W  PC of the word on `icu_data`; qualified by `icu_data_vld`.
- `stall`  in  1  decode backpressure; 1 = decode does not consume this cycle.
- `iq_full`  out  1  to fetch control; blocks new fetch requests.
- `iq_vld`  out  1  head entry valid.
- `iq_instr`  out  INSTR_W  head instruction.
- `iq_pc`  out  PC_W  head PC.
- `iq_cnt`  out  $clog2(DEPTH)+1  current occupancy.
- `iq_ovf`  out  1  sticky overflow error flag, for verification.

## Operation

- Storage is a circular flop array with `wr_ptr`, `rd_ptr` and `cnt`. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push is `icu_data_vld & ~flush`. The entry {`icu_data`, `fetch_pc`} is written at `wr_ptr`, and `wr_ptr` increments.
- Pop is `iq_vld & ~stall & ~flush`. `rd_ptr` increments.
- Occupancy update: `cnt` next = `cnt` + push − pop.
- Push and pop in the same cycle:
  - Legal at any occupancy, including `cnt == DEPTH`.
  - At `cnt == DEPTH` the push is accepted because a slot frees in the same cycle.
  - `cnt` is unchanged.
- Push at `cnt == DEPTH` without a pop:
  - The entry is dropped and no state changes.
  - `iq_ovf` is set and stays set until reset.
- Flush (wins over everything):
  - `cnt`, `wr_ptr` and `rd_ptr` go to 0 at the next edge.
  - A push in the flush cycle is dropped; that word belongs to the old stream.
  - A pop in the flush cycle is suppressed.
- `iq_full` is `cnt >= DEPTH-1`.
  - Fetch control allows at most one fetch outstanding. Asserting full one entry early guarantees that fetch a slot.
- `iq_vld` is `cnt != 0`. `iq_instr` and `iq_pc` come from the entry at `rd_ptr`.
  - These outputs are don't-care when `iq_vld == 0`.
  - When `iq_vld == 1` they are held stable while `stall` is 1.
- Data storage is not reset; only pointers, `cnt` and `iq_ovf` are reset.

## Timing

- Reset values: `iq_vld` = 0, `iq_full` = 0, `iq_cnt` = 0, `iq_ovf` = 0. `iq_instr` and `iq_pc` are undefined.
- Write-to-read latency is 1 cycle. A word pushed in cycle N is visible on `iq_vld`/`iq_instr` in cycle N+1. There is no combinational bypass from `icu_data` to outputs.
- `iq_full`, `iq_vld` and `iq_cnt` are purely registered-state functions. There is no combinational path from any input.
  - This matters because fetch control uses `iq_full` combinationally in its request and stall logic.
- Flush in cycle N gives `iq_vld` = 0 and `iq_full` = 0 in cycle N+1. The earliest new-stream entry is visible in N+2.
- Reset asserted mid-operation clears all control state immediately (asynchronous). The first push is accepted in the first cycle after `resetn` rises.

## Structure

- Shared package `c7bifu_pkg` holds:
  - `IQ_DEPTH` default;
  - `INSTR_W` and `PC_W`;
  - a packed `iq_entry_t` struct {instr, pc}, for reuse by decode.
- One sub-module, `c7bifu_iq_ptr`, holds the pointer/count logic.
  - Inputs: push, pop, flush.
  - Outputs: `wr_ptr`, `rd_ptr`, `cnt`, full, empty.
  - Instantiated once. The entry array and the overflow flag live in the top.
- Flops use the team's async-reset register cells; data entries use enable-only cells.

## Test plan

- Fill/drain: push 0x00000013 at PCs 0x1C000000, 0x1C000004 and 0x1C000008 with `stall` = 1.
  - `iq_cnt` steps 1, 2, 3; `iq_full` = 1 from `cnt` = 3.
  - Release `stall`: entries appear in order, one per cycle, then `iq_vld` = 0.
- Wrap-around: run 10 push/pop pairs with `DEPTH` = 4 and `stall` = 0.
  - Each word appears 1 cycle after its push; `cnt` never exceeds 1; PCs are in order.
- Simultaneous push and pop at `cnt` = 4, with `stall` = 0 and `icu_data_vld` = 1.
  - `cnt` stays 4, the new entry is queued last, and `iq_ovf` stays 0.
- Overflow: push at `cnt` = 4 with `stall` = 1.
  - The word is dropped, `iq_ovf` = 1 and stays 1, and `cnt` stays 4.
- Flush with a coincident push, at `cnt` = 2.
  - Next cycle `cnt` = 0, `iq_vld` = 0 and `iq_full` = 0; the coincident word is never output.
  - A push in the following cycle appears in flush cycle + 2.
- Async reset: pulse `resetn` low mid-cycle at `cnt` = 3.
  - Outputs clear immediately, before the next clock edge.
  - The first post-reset push of PC 0x1C000000 is output correctly.

Source files
------------

// File: rtl/c7bifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c7bifu_pkg
//  Description : Shared fetch-unit constants and the instruction-queue entry
//                type, reused by the queue and by decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package c7bifu_pkg;

    localparam int IQ_DEPTH = 4;
    localparam int INSTR_W  = 32;
    localparam int PC_W     = 32;

    // One queued fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/c7bifu_iq_if.sv
`default_nettype none
// ============================================================================
//  Module      : c7bifu_iq_if
//  Description : Fetch/ICU-return and decode-side signals of the instruction
//                queue. The master drives the ICU return, flush and stall;
//                the slave is the queue itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface c7bifu_iq_if #(
    parameter int DEPTH   = c7bifu_pkg::IQ_DEPTH,
    parameter int INSTR_W = c7bifu_pkg::INSTR_W,
    parameter int PC_W    = c7bifu_pkg::PC_W
) ();

    logic                     flush;
    logic                     icu_data_vld;
    logic [INSTR_W-1:0]       icu_data;
    logic [PC_W-1:0]          fetch_pc;
    logic                     stall;
    logic                     iq_full;
    logic                     iq_vld;
    logic [INSTR_W-1:0]       iq_instr;
    logic [PC_W-1:0]          iq_pc;
    logic [$clog2(DEPTH):0]   iq_cnt;
    logic                     iq_ovf;

    modport master (
        output flush, icu_data_vld, icu_data, fetch_pc, stall,
        input  iq_full, iq_vld, iq_instr, iq_pc, iq_cnt, iq_ovf
    );

    modport slave (
        input  flush, icu_data_vld, icu_data, fetch_pc, stall,
        output iq_full, iq_vld, iq_instr, iq_pc, iq_cnt, iq_ovf
    );

endinterface
`default_nettype wire

// File: rtl/c7bifu_iq_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : c7bifu_iq_ptr
//  Description : Write/read pointers and occupancy count of the instruction
//                queue. Callers present only accepted push/pop strobes;
//                flush returns everything to empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module c7bifu_iq_ptr
    import c7bifu_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic          i_flush,
    output logic [AW-1:0]      o_wr_ptr,
    output logic [AW-1:0]      o_rd_ptr,
    output logic [CW-1:0]      o_cnt,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;

    // Pointer and count update; flush empties the queue over any push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_cnt    = r_cnt;
    assign o_full   = (r_cnt == c_cnt_full);
    assign o_empty  = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/c7bifu_iq.sv
`default_nettype none
// ============================================================================
//  Module      : c7bifu_iq
//  Description : Instruction queue between the ICU return path and decode.
//                Captures {instr, pc} per valid ICU word, presents the oldest
//                entry to decode, raises iq_full one entry early so the single
//                outstanding fetch always has a slot, and empties on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module c7bifu_iq #(
    parameter int DEPTH   = c7bifu_pkg::IQ_DEPTH,
    parameter int INSTR_W = c7bifu_pkg::INSTR_W,
    parameter int PC_W    = c7bifu_pkg::PC_W
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    c7bifu_iq_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_lvl = CW'(DEPTH - 1);

    logic [AW-1:0]      w_wr_ptr;
    logic [AW-1:0]      w_rd_ptr;
    logic [CW-1:0]      w_cnt;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic               r_ovf;

    // A push on a full queue is still taken when a pop frees a slot this cycle.
    assign w_push_req = bus.icu_data_vld & ~bus.flush;
    assign w_pop      = ~w_empty & ~bus.stall & ~bus.flush;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    c7bifu_iq_ptr #(
        .DEPTH    (DEPTH)
    ) u_ptr (
        .clk      (clk),
        .resetn   (resetn),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (bus.flush),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_cnt    (w_cnt),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Entry storage: enable-only, not reset, written at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[w_wr_ptr] <= bus.icu_data;
            r_pc[w_wr_ptr]    <= bus.fetch_pc;
        end
    end

    // Sticky overflow: a dropped push is remembered until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

    // Status outputs depend on registered state only; fetch control uses
    // iq_full combinationally.
    assign bus.iq_full  = (w_cnt >= c_full_lvl);
    assign bus.iq_vld   = ~w_empty;
    assign bus.iq_cnt   = w_cnt;
    assign bus.iq_ovf   = r_ovf;
    assign bus.iq_instr = r_instr[w_rd_ptr];
    assign bus.iq_pc    = r_pc[w_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_c7bifu_iq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c7bifu_iq
//  Description : Self-checking bench for c7bifu_iq with a queue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c7bifu_iq;
    import c7bifu_pkg::*;

    localparam int TB_DEPTH = IQ_DEPTH;

    logic clk = 1'b0;
    logic resetn;

    int        n_cmp = 0;
    int        n_mis = 0;
    iq_entry_t sb_q[$];
    bit        m_ovf = 1'b0;

    always #5 clk = ~clk;

    c7bifu_iq_if #(.DEPTH(TB_DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

    c7bifu_iq #(
        .DEPTH   (TB_DEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Status outputs against the scoreboard's current occupancy.
    task automatic check_status(input string tag);
        check({tag, ".cnt"},  64'(bus.iq_cnt),  64'(sb_q.size()));
        check({tag, ".vld"},  64'(bus.iq_vld),  64'(sb_q.size() != 0));
        check({tag, ".full"}, 64'(bus.iq_full), 64'(sb_q.size() >= TB_DEPTH - 1));
        check({tag, ".ovf"},  64'(bus.iq_ovf),  64'(m_ovf));
    endtask

    // One cycle: drive inputs, compare outputs with the scoreboard head,
    // update the scoreboard with what the inputs should do, then clock.
    task automatic step(input bit vld, input logic [31:0] instr, input logic [31:0] pc,
                        input bit stl, input bit fl);
        bit        pop;
        bit        push;
        bit        acc;
        iq_entry_t e;
        bus.icu_data_vld = vld;
        bus.icu_data     = instr;
        bus.fetch_pc     = pc;
        bus.stall        = stl;
        bus.flush        = fl;
        #1;
        check_status("step");
        if (sb_q.size() != 0) begin
            check("head.instr", 64'(bus.iq_instr), 64'(sb_q[0].instr));
            check("head.pc",    64'(bus.iq_pc),    64'(sb_q[0].pc));
        end
        pop  = (sb_q.size() != 0) && !stl && !fl;
        push = vld && !fl;
        acc  = push && ((sb_q.size() < TB_DEPTH) || pop);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (push && !acc) m_ovf = 1'b1;
            if (pop) void'(sb_q.pop_front());
            if (acc) begin
                e.instr = instr;
                e.pc    = pc;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit stl);
        step(1'b0, 32'h0, 32'h0, stl, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn           = 1'b0;
        bus.flush        = 1'b0;
        bus.icu_data_vld = 1'b0;
        bus.icu_data     = '0;
        bus.fetch_pc     = '0;
        bus.stall        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        resetn = 1'b1;

        // Fill three under stall, then drain in order.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0013, 32'h1C00_0000 + 32'(4 * i), 1'b1, 1'b0);
        idle(1'b1);
        repeat (4) idle(1'b0);

        // Wrap-around: back-to-back push/pop pairs.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h0000_1000 + 32'(i), 32'h1C00_1000 + 32'(4 * i), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Fill to DEPTH, then push and pop together at full.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_2000 + 32'(i), 32'h1C00_2000 + 32'(4 * i), 1'b1, 1'b0);
        step(1'b1, 32'h0000_2AAA, 32'h1C00_2010, 1'b0, 1'b0);
        idle(1'b1);

        // Overflow: push at full under stall is dropped, flag is sticky.
        step(1'b1, 32'h0000_DEAD, 32'h1C00_DEAD, 1'b1, 1'b0);
        idle(1'b1);
        repeat (5) idle(1'b0);

        // Flush at cnt=2 with a coincident push, new stream right after.
        step(1'b1, 32'h0000_3000, 32'h1C00_3000, 1'b1, 1'b0);
        step(1'b1, 32'h0000_3001, 32'h1C00_3004, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0BAD, 32'h1C00_0BAD, 1'b1, 1'b1);
        step(1'b1, 32'h0000_4000, 32'h1C00_4000, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Asynchronous reset mid-cycle at cnt=3.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_5000 + 32'(i), 32'h1C00_5000 + 32'(4 * i), 1'b1, 1'b0);
        bus.icu_data_vld = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        sb_q.delete();
        m_ovf = 1'b0;
        check_status("async_rst");
        @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        step(1'b1, 32'h0000_0013, 32'h1C00_0000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
